master_cnn_div_seq: RTL and testbench
=====================================

Name: master_cnn_div_seq

Overview:
Sequential signed-by-unsigned divider. It is the inverse of the CNN datapath's unsigned-17 × signed-18 → signed-35 DSP multiplier. It takes a signed 35-bit product-width dividend and an unsigned 17-bit divisor, and returns a signed 18-bit quotient. Use: de-normalising accumulated conv results (divide by window/scale factors) inside MASTER_CNN. It is a restoring radix-2 divider, one quotient bit per cycle, driven by an ap_start/ap_done handshake.

Parameters:
DIN0_WIDTH, 35, dividend width (signed)
DIN1_WIDTH, 17, divisor width (unsigned)
DOUT_WIDTH, 18, quotient width (signed); must satisfy DOUT_WIDTH = DIN0_WIDTH - DIN1_WIDTH

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  request; sampled only when ap_idle=1
ap_idle  out  1  high in IDLE; operands are accepted this cycle if ap_start=1
ap_done  out  1  one-cycle pulse when dout and flags become valid
din0  in  DIN0_WIDTH  signed dividend
din1  in  DIN1_WIDTH  unsigned divisor
dout  out  DOUT_WIDTH  signed quotient, truncated toward zero, saturated
overflow  out  1  quotient saturated (valid with ap_done, held after)
div_by_zero  out  1  din1 was 0 (valid with ap_done, held after)

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; ap_idle=1; ap_done=0; dout=0; overflow=0; div_by_zero=0; all internal registers cleared.
- Reset mid-operation aborts the division. No ap_done is issued.
- States:
  - IDLE: if ap_start=1, register |din0| (35-bit unsigned), the sign of din0, din1, and a zero-divisor flag; go to CALC and load bit counter = DIN0_WIDTH-1.
  - CALC: shift partial remainder left and bring in the next dividend MSB. If remainder ≥ divisor, subtract and set quotient bit to 1. Decrement counter. Go to FIX after the iteration where counter=0, i.e. exactly DIN0_WIDTH cycles in CALC.
  - FIX: apply sign, saturation and zero-divisor rules; register dout and flags; go to DONE.
  - DONE: ap_done=1 for this single cycle; go to IDLE.
- Latency: start accepted at edge E0; ap_done is high in the cycle after edge E0+DIN0_WIDTH+1, which is 36 edges at default widths. Throughput is one division per DIN0_WIDTH+3 cycles.
- ap_start while not IDLE is ignored, not queued. din0 and din1 are don't-care after the accept edge.
- Quotient sign = sign(din0), since the divisor is unsigned. The full 35-bit magnitude quotient is computed internally.
- Saturation:
  - positive result with magnitude > 2^17-1 → dout=131071, overflow=1
  - negative result with magnitude > 2^17 → dout=-131072, overflow=1
  - magnitude exactly 2^17 with a negative sign is representable: no overflow
- din1=0: same latency; dout=131071 if din0 ≥ 0, else -131072; div_by_zero=1; overflow=0.
- din0=-2^34 (most-negative): magnitude 2^34 fits the 35-bit unsigned register; no special case.
- dout, overflow and div_by_zero hold their values until the next FIX.

Optional Feature:
Macro MASTER_CNN_DIV_REM_EN.
- Defined: adds output port rem, signed DIN1_WIDTH+1 bits. rem = remainder with the sign of din0, satisfying din0 = q·din1 + rem with |rem| < din1. Valid with ap_done and held after; reset value 0. On overflow or div_by_zero, rem=0.
- Undefined: no rem port. The remainder register may be trimmed, but the CALC datapath is unchanged. Latency is identical in both builds.

Test Plan:
- Basic: din0=1000, din1=7 → ap_done 36 edges after accept; dout=142, overflow=0, div_by_zero=0 (rem=6 with REM_EN).
- Sign: din0=-1000, din1=7 → dout=-142 (rem=-6); din0=-131072, din1=1 → dout=-131072, overflow=0.
- Saturation: din0=2^34-1, din1=1 → dout=131071, overflow=1; din0=-2^34, din1=1 → dout=-131072, overflow=1.
- Divide by zero: din0=5, din1=0 → dout=131071, div_by_zero=1; din0=-5, din1=0 → dout=-131072, div_by_zero=1.
- Handshake: pulse ap_start again 10 cycles into CALC with different operands → ignored; exactly one ap_done carrying the first result. ap_idle=0 from accept until DONE.
- Reset and round-trip: drop ap_rst_n mid-CALC → outputs 0, ap_idle=1, no ap_done. Then run 1000 random pairs p=a·b (a unsigned-17 nonzero, b signed-18) with din0=p, din1=a → dout=b, overflow=0.

Source files
------------

// File: rtl/master_cnn_div_seq.sv
// ---------------------------------------------------------------------------
// master_cnn_div_seq
// Sequential restoring radix-2 divider: signed DIN0_WIDTH-bit dividend by an
// unsigned DIN1_WIDTH-bit divisor, producing a signed DOUT_WIDTH-bit quotient
// truncated toward zero and saturated. This is the inverse of the CNN
// datapath's unsigned-17 x signed-18 multiplier and is used to de-normalise
// accumulated conv results. One quotient bit is resolved per clock.
//
// Optional build macro: MASTER_CNN_DIV_REM_EN adds the signed remainder port.
//
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst_n     asynchronous active-low reset (synchronous release upstream)
//   ap_start     request; sampled only while ap_idle=1
//   ap_idle      high in IDLE; operands accepted on this cycle if ap_start=1
//   ap_done      one-cycle pulse when dout/flags become valid
//   din0         signed dividend
//   din1         unsigned divisor
//   dout         signed quotient (held until the next result)
//   overflow     quotient saturated (held)
//   div_by_zero  divisor was zero (held)
//   rem          signed remainder, sign of din0 (only with MASTER_CNN_DIV_REM_EN)
// ---------------------------------------------------------------------------
module master_cnn_div_seq #(
  parameter int DIN0_WIDTH = 35,
  parameter int DIN1_WIDTH = 17,
  parameter int DOUT_WIDTH = 18
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  output logic                         ap_idle,
  output logic                         ap_done,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic        [DIN1_WIDTH-1:0] din1,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         overflow,
  output logic                         div_by_zero
`ifdef MASTER_CNN_DIV_REM_EN
  ,
  output logic signed [DIN1_WIDTH:0]   rem
`endif
);

  // Partial remainder is one bit wider than the divisor: after the shift it
  // can reach 2*divisor-1.
  localparam int RW = DIN1_WIDTH + 1;
  localparam int CW = $clog2(DIN0_WIDTH);

  localparam logic [CW-1:0]         CNT_LOAD  = CW'(DIN0_WIDTH - 1);
  localparam logic [DIN0_WIDTH-1:0] ONE_W0    = DIN0_WIDTH'(1);
  localparam logic [DOUT_WIDTH-1:0] ONE_OUT   = DOUT_WIDTH'(1);
  // Largest magnitudes representable for positive / negative results.
  localparam logic [DIN0_WIDTH-1:0] POS_LIMIT =
    {{(DIN0_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DIN0_WIDTH-1:0] NEG_LIMIT =
    {{(DIN0_WIDTH-DOUT_WIDTH){1'b0}}, 1'b1, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic [DOUT_WIDTH-1:0] DOUT_MAX  = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] DOUT_MIN  = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DIN0_WIDTH-1:0]   dvd_q, dvd_d;        // dividend magnitude, becomes quotient
  logic [RW-1:0]           prem_q, prem_d;      // partial remainder
  logic [DIN1_WIDTH-1:0]   divisor_q, divisor_d;
  logic                    sign_q, sign_d;
  logic                    zero_q, zero_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DOUT_WIDTH-1:0]   dout_q, dout_d;
  logic                    ovf_q, ovf_d;
  logic                    dz_q, dz_d;
  logic                    ap_done_q, ap_done_d;
  logic                    ap_idle_q, ap_idle_d;
`ifdef MASTER_CNN_DIV_REM_EN
  logic [RW-1:0]           rem_q, rem_d;
  logic [RW-1:0]           fix_rem;
`endif

  logic [DIN0_WIDTH-1:0]   din0_u;
  logic [DIN0_WIDTH-1:0]   din0_abs;
  logic [RW-1:0]           prem_shift;
  logic [RW-1:0]           divisor_ext;
  logic [RW-1:0]           prem_sub;
  logic                    prem_ge;
  logic [DOUT_WIDTH-1:0]   q_low;
  logic [DOUT_WIDTH-1:0]   fix_dout;
  logic                    fix_ovf;

  assign din0_u      = din0;
  // Two's-complement negate; -2^MSB maps to 2^MSB, which still fits unsigned.
  assign din0_abs    = din0_u[DIN0_WIDTH-1] ? (~din0_u + ONE_W0) : din0_u;
  assign prem_shift  = {prem_q[RW-2:0], dvd_q[DIN0_WIDTH-1]};
  assign divisor_ext = {1'b0, divisor_q};
  assign prem_sub    = prem_shift - divisor_ext;
  assign prem_ge     = (prem_shift >= divisor_ext);
  assign q_low       = dvd_q[DOUT_WIDTH-1:0];

  // Result shaping: zero divisor first, then saturation, then sign.
  always_comb begin
    fix_dout = sign_q ? (~q_low + ONE_OUT) : q_low;
    fix_ovf  = 1'b0;
`ifdef MASTER_CNN_DIV_REM_EN
    fix_rem  = sign_q ? (~prem_q + RW'(1)) : prem_q;
`endif
    if (zero_q) begin
      fix_dout = sign_q ? DOUT_MIN : DOUT_MAX;
`ifdef MASTER_CNN_DIV_REM_EN
      fix_rem  = '0;
`endif
    end else if (!sign_q && (dvd_q > POS_LIMIT)) begin
      fix_dout = DOUT_MAX;
      fix_ovf  = 1'b1;
`ifdef MASTER_CNN_DIV_REM_EN
      fix_rem  = '0;
`endif
    end else if (sign_q && (dvd_q > NEG_LIMIT)) begin
      fix_dout = DOUT_MIN;
      fix_ovf  = 1'b1;
`ifdef MASTER_CNN_DIV_REM_EN
      fix_rem  = '0;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    prem_d    = prem_q;
    divisor_d = divisor_q;
    sign_d    = sign_q;
    zero_d    = zero_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
`ifdef MASTER_CNN_DIV_REM_EN
    rem_d     = rem_q;
`endif
    ap_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          dvd_d     = din0_abs;
          prem_d    = '0;
          divisor_d = din1;
          sign_d    = din0_u[DIN0_WIDTH-1];
          zero_d    = (din1 == '0);
          cnt_d     = CNT_LOAD;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        // Quotient bits shift into the dividend register as its MSBs leave.
        prem_d = prem_ge ? prem_sub : prem_shift;
        dvd_d  = {dvd_q[DIN0_WIDTH-2:0], prem_ge};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        dout_d    = fix_dout;
        ovf_d     = fix_ovf;
        dz_d      = zero_q;
`ifdef MASTER_CNN_DIV_REM_EN
        rem_d     = fix_rem;
`endif
        ap_done_d = 1'b1;
        state_d   = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ap_idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= S_IDLE;
      dvd_q     <= '0;
      prem_q    <= '0;
      divisor_q <= '0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      cnt_q     <= '0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
`ifdef MASTER_CNN_DIV_REM_EN
      rem_q     <= '0;
`endif
      ap_done_q <= 1'b0;
      ap_idle_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      prem_q    <= prem_d;
      divisor_q <= divisor_d;
      sign_q    <= sign_d;
      zero_q    <= zero_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
`ifdef MASTER_CNN_DIV_REM_EN
      rem_q     <= rem_d;
`endif
      ap_done_q <= ap_done_d;
      ap_idle_q <= ap_idle_d;
    end
  end

  assign ap_idle     = ap_idle_q;
  assign ap_done     = ap_done_q;
  assign dout        = dout_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dz_q;
`ifdef MASTER_CNN_DIV_REM_EN
  assign rem         = rem_q;
`endif

endmodule

// File: tb/tb_master_cnn_div_seq.sv
// ---------------------------------------------------------------------------
// tb_master_cnn_div_seq
// Self-checking bench for master_cnn_div_seq. Expected results come from a
// behavioural model (integer divide with sign/saturation rules) pushed to a
// scoreboard queue at start time and compared when ap_done pulses.
// ---------------------------------------------------------------------------
module tb_master_cnn_div_seq;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b1;
  logic               ap_start = 1'b0;
  logic               ap_idle;
  logic               ap_done;
  logic signed [34:0] din0 = '0;
  logic        [16:0] din1 = '0;
  logic signed [17:0] dout;
  logic               overflow;
  logic               div_by_zero;
`ifdef MASTER_CNN_DIV_REM_EN
  logic signed [17:0] rem;
`endif

  always #5 ap_clk = ~ap_clk;

  master_cnn_div_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .din0        (din0),
    .din1        (din1),
    .dout        (dout),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
`ifdef MASTER_CNN_DIV_REM_EN
    ,
    .rem         (rem)
`endif
  );

  typedef struct {
    logic signed [17:0] dout;
    logic               ovf;
    logic               dz;
    logic signed [17:0] rem;
    longint             a;
    longint             b;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;

  function automatic exp_t model(input longint a, input longint b);
    exp_t   e;
    longint mag, q, r;
    bit     neg;
    neg   = (a < 0);
    mag   = neg ? -a : a;
    e.a   = a;
    e.b   = b;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    e.rem = '0;
    if (b == 0) begin
      e.dz   = 1'b1;
      e.dout = neg ? -18'sd131072 : 18'sd131071;
    end else begin
      q = mag / b;
      r = mag % b;
      if (!neg && q > 131071) begin
        e.dout = 18'sd131071;
        e.ovf  = 1'b1;
      end else if (neg && q > 131072) begin
        e.dout = -18'sd131072;
        e.ovf  = 1'b1;
      end else begin
        e.dout = 18'(neg ? -q : q);
        e.rem  = 18'(neg ? -r : r);
      end
    end
    return e;
  endfunction

  // Scoreboard: compare every ap_done against the oldest expectation.
  always begin : monitor
    exp_t e;
    bit   bad;
    @(negedge ap_clk);
    if (ap_rst_n === 1'b1 && ap_done === 1'b1) begin
      done_count++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done dout=%0d expected no ap_done", dout);
      end else begin
        e   = sb_q.pop_front();
        bad = (dout !== e.dout) || (overflow !== e.ovf) || (div_by_zero !== e.dz);
`ifdef MASTER_CNN_DIV_REM_EN
        if (rem !== e.rem) bad = 1'b1;
`endif
        if (bad) begin
          failures++;
          $display("FAIL result a=%0d b=%0d got dout=%0d ovf=%0b dz=%0b, expected dout=%0d ovf=%0b dz=%0b",
                   e.a, e.b, dout, overflow, div_by_zero, e.dout, e.ovf, e.dz);
`ifdef MASTER_CNN_DIV_REM_EN
          $display("FAIL result_rem a=%0d b=%0d got rem=%0d expected rem=%0d", e.a, e.b, rem, e.rem);
`endif
        end else begin
          $display("ok a=%0d b=%0d dout=%0d ovf=%0b dz=%0b", e.a, e.b, dout, overflow, div_by_zero);
        end
      end
    end
  end

  // Starts one division from a negedge; returns one negedge after the accept edge.
  task automatic start_div(input longint a, input longint b);
    int n;
    n = 0;
    while (ap_idle !== 1'b1 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout ap_idle=%0b expected 1 within 200 cycles", ap_idle);
    end
    din0     = 35'(a);
    din1     = 17'(b);
    ap_start = 1'b1;
    sb_q.push_back(model(a, b));
    @(negedge ap_clk);
    ap_start = 1'b0;
    din0     = 35'(longint'($urandom));
    din1     = 17'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout pending=%0d expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    #2 ap_rst_n = 1'b0;
    #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || dout !== 18'sd0 ||
        overflow !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state idle=%0b done=%0b dout=%0d ovf=%0b dz=%0b expected 1 0 0 0 0",
               ap_idle, ap_done, dout, overflow, div_by_zero);
    end
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || dout !== 18'sd0) begin
      failures++;
      $display("FAIL post_reset idle=%0b done=%0b dout=%0d expected 1 0 0", ap_idle, ap_done, dout);
    end
  endtask

  task automatic test_basic();
    int k;
    start_div(1000, 7);
    checks++;
    if (ap_idle !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_accept ap_idle=%0b expected 0", ap_idle);
    end
    k = 1;
    while (ap_done !== 1'b1 && k < 100) begin
      @(negedge ap_clk);
      k++;
    end
    checks++;
    if (k != 37) begin
      failures++;
      $display("FAIL latency cycles=%0d expected 37", k);
    end
    wait_drain();
  endtask

  task automatic test_sign();
    start_div(-1000, 7);
    start_div(-131072, 1);
    start_div(-5, 7);
    start_div(123456789, 131071);
    wait_drain();
  endtask

  task automatic test_saturation();
    start_div(64'sd17179869183, 1);
    start_div(-64'sd17179869184, 1);
    start_div(131072, 1);
    start_div(-131073, 1);
    wait_drain();
  endtask

  task automatic test_div_zero();
    start_div(5, 0);
    start_div(-5, 0);
    start_div(0, 0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int n, d0;
    bit idle_bad;
    d0 = done_count;
    start_div(30000, 3);
    idle_bad = 1'b0;
    n = 1;
    while (ap_done !== 1'b1 && n < 100) begin
      if (ap_idle !== 1'b0) idle_bad = 1'b1;
      if (n == 10) begin
        ap_start = 1'b1;
        din0     = 35'sd777;
        din1     = 17'd5;
      end
      if (n == 11) ap_start = 1'b0;
      @(negedge ap_clk);
      n++;
    end
    checks++;
    if (idle_bad || ap_idle !== 1'b0) begin
      failures++;
      $display("FAIL idle_during_op bad=%0b idle_at_done=%0b expected 0 0", idle_bad, ap_idle);
    end
    wait_drain();
    repeat (45) @(negedge ap_clk);
    checks++;
    if (done_count != d0 + 1 || ap_idle !== 1'b1) begin
      failures++;
      $display("FAIL ignored_start dones=%0d idle=%0b expected %0d 1", done_count - d0, ap_idle, 1);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    start_div(12345, 3);
    repeat (10) @(negedge ap_clk);
    d0 = done_count;
    ap_rst_n = 1'b0;
    #1;
    sb_q.delete();
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || dout !== 18'sd0 ||
        overflow !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset idle=%0b done=%0b dout=%0d ovf=%0b dz=%0b expected 1 0 0 0 0",
               ap_idle, ap_done, dout, overflow, div_by_zero);
    end
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (50) @(negedge ap_clk);
    checks++;
    if (done_count != d0) begin
      failures++;
      $display("FAIL aborted_done dones=%0d expected 0", done_count - d0);
    end
  endtask

  task automatic test_round_trip();
    longint a, b;
    for (int i = 0; i < 1000; i++) begin
      a = longint'($urandom_range(131071, 1));
      b = longint'($urandom_range(262143, 0)) - 131072;
      start_div(a * b, a);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_saturation();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    repeat (5) @(negedge ap_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
